// File: rtl/ex_mem_if.sv
// ex_mem_if: execute-to-memory pipeline register bus.
// The master side is the execute stage / control logic that drives the ex_* fields,
// the multiply-accumulate scratch inputs, the stall vector and flush.
// The slave side is the ex_mem register, which returns the mem_* fields and the scratch state.
interface ex_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ex_waddr;
    logic              ex_we;
    logic [DATA_W-1:0] ex_wdata;
    logic              ex_whilo;
    logic [DATA_W-1:0] ex_hi;
    logic [DATA_W-1:0] ex_lo;
    logic [63:0]       hilo_temp_i;
    logic [1:0]        cnt_i;
    logic [5:0]        stall;
    logic              flush;

    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_whilo;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic [63:0]       hilo_temp_o;
    logic [1:0]        cnt_o;

    modport master (
        output ex_waddr, ex_we, ex_wdata, ex_whilo, ex_hi, ex_lo,
        output hilo_temp_i, cnt_i, stall, flush,
        input  mem_waddr, mem_we, mem_wdata, mem_whilo, mem_hi, mem_lo,
        input  hilo_temp_o, cnt_o
    );

    modport slave (
        input  ex_waddr, ex_we, ex_wdata, ex_whilo, ex_hi, ex_lo,
        input  hilo_temp_i, cnt_i, stall, flush,
        output mem_waddr, mem_we, mem_wdata, mem_whilo, mem_hi, mem_lo,
        output hilo_temp_o, cnt_o
    );
endinterface

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register of the five-stage MIPS core.
// Priority at each edge: reset, flush, bubble (EX stalled, MEM running),
// advance (EX running), hold (EX and MEM stalled).
// The multiply-accumulate scratch (hilo_temp, cnt) is kept alive only while EX is stalled,
// so a two-cycle madd/msub can see its first-cycle result.
// Optional feature macro: EX_MEM_HILO_EN. When it is undefined, the HI/LO and scratch flops
// are not built, and their outputs are tied to zero.
module ex_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic      clk,
    input logic      rst,
    ex_mem_if.slave  bus
);

    logic ex_stalled;
    logic mem_stalled;
    logic bubble;
    logic advance;

    assign ex_stalled  = bus.stall[3];
    assign mem_stalled = bus.stall[4];
    assign bubble      = ex_stalled && !mem_stalled;
    // stall[4] without stall[3] is not a legal control pattern; it is treated as an advance.
    assign advance     = !ex_stalled;

    // Stall bits belonging to other pipeline stages are not used here.
    logic unused_stall;
    assign unused_stall = ^{bus.stall[5], bus.stall[2:0]};

    logic [ADDR_W-1:0] mem_waddr_d, mem_waddr_q;
    logic              mem_we_d,    mem_we_q;
    logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;

    // Next-state selection for the register-write fields; holding is the default.
    always_comb begin
        mem_waddr_d = mem_waddr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        if (bus.flush || bubble) begin
            mem_waddr_d = '0;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
        end else if (advance) begin
            mem_waddr_d = bus.ex_waddr;
            mem_we_d    = bus.ex_we;
            mem_wdata_d = bus.ex_wdata;
        end
    end

    // Register-write flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_waddr_q <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_waddr_q <= mem_waddr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef EX_MEM_HILO_EN
    logic              mem_whilo_d, mem_whilo_q;
    logic [DATA_W-1:0] mem_hi_d,    mem_hi_q;
    logic [DATA_W-1:0] mem_lo_d,    mem_lo_q;
    logic [63:0]       hilo_temp_d, hilo_temp_q;
    logic [1:0]        cnt_d,       cnt_q;

    // HI/LO fields follow the same rules as the register-write fields; the scratch
    // is captured whenever EX is stalled and cleared whenever EX moves on or is flushed.
    always_comb begin
        mem_whilo_d = mem_whilo_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        hilo_temp_d = bus.hilo_temp_i;
        cnt_d       = bus.cnt_i;
        if (bus.flush) begin
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end else if (bubble) begin
            mem_whilo_d = 1'b0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
        end else if (advance) begin
            mem_whilo_d = bus.ex_whilo;
            mem_hi_d    = bus.ex_hi;
            mem_lo_d    = bus.ex_lo;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end
    end

    // HI/LO and scratch flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_whilo_q <= 1'b0;
            mem_hi_q    <= '0;
            mem_lo_q    <= '0;
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end else begin
            mem_whilo_q <= mem_whilo_d;
            mem_hi_q    <= mem_hi_d;
            mem_lo_q    <= mem_lo_d;
            hilo_temp_q <= hilo_temp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.mem_whilo   = mem_whilo_q;
    assign bus.mem_hi      = mem_hi_q;
    assign bus.mem_lo      = mem_lo_q;
    assign bus.hilo_temp_o = hilo_temp_q;
    assign bus.cnt_o       = cnt_q;
`else
    // HI/LO support is not built, so these inputs are intentionally ignored.
    logic unused_hilo;
    assign unused_hilo = ^{bus.ex_whilo, bus.ex_hi, bus.ex_lo, bus.hilo_temp_i, bus.cnt_i};

    assign bus.mem_whilo   = 1'b0;
    assign bus.mem_hi      = '0;
    assign bus.mem_lo      = '0;
    assign bus.hilo_temp_o = '0;
    assign bus.cnt_o       = '0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: testbench for the EX/MEM pipeline register.
// It uses a table of per-edge vectors, followed by a few hand-written multi-cycle sequences.
// Expectations for the HI/LO and scratch fields are zero unless EX_MEM_HILO_EN is defined.
module tb_ex_mem;

`ifdef EX_MEM_HILO_EN
    localparam bit HILO_EN = 1'b1;
`else
    localparam bit HILO_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    ex_mem_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    ex_mem #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [5:0]  stall;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] ht;
        logic [1:0]  cnt;
        logic [4:0]  e_waddr;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_whilo;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic [63:0] e_ht;
        logic [1:0]  e_cnt;
    } vec_t;

    int checks;
    int failures;

    // Compares one field and reports a failure line when it differs.
    task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one vector's inputs and advances to just after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        rst             = v.rst;
        bus.flush       = v.flush;
        bus.stall       = v.stall;
        bus.ex_waddr    = v.waddr;
        bus.ex_we       = v.we;
        bus.ex_wdata    = v.wdata;
        bus.ex_whilo    = v.whilo;
        bus.ex_hi       = v.hi;
        bus.ex_lo       = v.lo;
        bus.hilo_temp_i = v.ht;
        bus.cnt_i       = v.cnt;
        @(posedge clk);
        #1;
    endtask

    // Compares all outputs against a vector's expectations; HI/LO fields are masked when disabled.
    task automatic checkOutput(input vec_t v, input string tag);
        checkField({tag, " mem_waddr"}, 64'(bus.mem_waddr), 64'(v.e_waddr));
        checkField({tag, " mem_we"},    64'(bus.mem_we),    64'(v.e_we));
        checkField({tag, " mem_wdata"}, 64'(bus.mem_wdata), 64'(v.e_wdata));
        checkField({tag, " mem_whilo"}, 64'(bus.mem_whilo), HILO_EN ? 64'(v.e_whilo) : 64'd0);
        checkField({tag, " mem_hi"},    64'(bus.mem_hi),    HILO_EN ? 64'(v.e_hi)    : 64'd0);
        checkField({tag, " mem_lo"},    64'(bus.mem_lo),    HILO_EN ? 64'(v.e_lo)    : 64'd0);
        checkField({tag, " hilo_temp_o"}, bus.hilo_temp_o,  HILO_EN ? v.e_ht         : 64'd0);
        checkField({tag, " cnt_o"},     64'(bus.cnt_o),     HILO_EN ? 64'(v.e_cnt)   : 64'd0);
    endtask

    vec_t vecs[14];

    initial begin
        checks   = 0;
        failures = 0;

        // rst fl  stall     waddr  we    wdata          whilo hi             lo            ht                      cnt  | expected
        vecs[0]  = '{1'b1, 1'b0, 6'b000000, 5'd7,  1'b1, 32'hAAAA_5555, 1'b1, 32'h11,        32'h22,       64'h33,                 2'd2,
                     5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,        64'h0,                  2'd0};
        vecs[1]  = vecs[0];
        vecs[2]  = '{1'b0, 1'b0, 6'b000000, 5'd7,  1'b1, 32'hAAAA_5555, 1'b1, 32'h11,        32'h22,       64'h33,                 2'd2,
                     5'd7,  1'b1, 32'hAAAA_5555, 1'b1, 32'h11,        32'h22,       64'h0,                  2'd0};
        vecs[3]  = '{1'b0, 1'b0, 6'b000000, 5'd3,  1'b1, 32'h0000_F0F0, 1'b0, 32'h0,         32'h0,        64'h0,                  2'd0,
                     5'd3,  1'b1, 32'h0000_F0F0, 1'b0, 32'h0,         32'h0,        64'h0,                  2'd0};
        vecs[4]  = '{1'b0, 1'b0, 6'b001111, 5'd9,  1'b1, 32'h1234_5678, 1'b1, 32'h5,         32'h6,        64'hA,                  2'd1,
                     5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,        64'hA,                  2'd1};
        vecs[5]  = '{1'b0, 1'b0, 6'b000000, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b1, 32'hCAFE,      32'hBEEF,     64'h7,                  2'd2,
                     5'd0,  1'b1, 32'hDEAD_BEEF, 1'b1, 32'hCAFE,      32'hBEEF,     64'h0,                  2'd0};
        vecs[6]  = '{1'b0, 1'b0, 6'b011111, 5'd4,  1'b0, 32'h1111_1111, 1'b0, 32'h0,         32'h0,        64'hB,                  2'd1,
                     5'd0,  1'b1, 32'hDEAD_BEEF, 1'b1, 32'hCAFE,      32'hBEEF,     64'hB,                  2'd1};
        vecs[7]  = '{1'b0, 1'b0, 6'b011111, 5'd4,  1'b0, 32'h2222_2222, 1'b0, 32'h0,         32'h0,        64'hC,                  2'd2,
                     5'd0,  1'b1, 32'hDEAD_BEEF, 1'b1, 32'hCAFE,      32'hBEEF,     64'hC,                  2'd2};
        vecs[8]  = '{1'b0, 1'b0, 6'b011111, 5'd4,  1'b0, 32'h3333_3333, 1'b0, 32'h0,         32'h0,        64'hD,                  2'd1,
                     5'd0,  1'b1, 32'hDEAD_BEEF, 1'b1, 32'hCAFE,      32'hBEEF,     64'hD,                  2'd1};
        vecs[9]  = '{1'b0, 1'b1, 6'b011111, 5'd4,  1'b1, 32'h4444_4444, 1'b1, 32'h1,         32'h1,        64'h5,                  2'd1,
                     5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,        64'h0,                  2'd0};
        vecs[10] = '{1'b0, 1'b0, 6'b000000, 5'd31, 1'b1, 32'h0BAD_F00D, 1'b1, 32'hFFFF_FFFF, 32'h1,        64'h0,                  2'd0,
                     5'd31, 1'b1, 32'h0BAD_F00D, 1'b1, 32'hFFFF_FFFF, 32'h1,        64'h0,                  2'd0};
        vecs[11] = '{1'b0, 1'b0, 6'b010000, 5'd2,  1'b0, 32'h5,         1'b0, 32'h0,         32'h0,        64'h9,                  2'd3,
                     5'd2,  1'b0, 32'h5,         1'b0, 32'h0,         32'h0,        64'h0,                  2'd0};
        vecs[12] = '{1'b0, 1'b0, 6'b001000, 5'd6,  1'b1, 32'h77,        1'b1, 32'h2,         32'h3,        64'hFFFF_FFFF_FFFF_FFFF, 2'd3,
                     5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,        64'hFFFF_FFFF_FFFF_FFFF, 2'd3};
        vecs[13] = '{1'b1, 1'b0, 6'b011111, 5'd8,  1'b1, 32'h99,        1'b1, 32'h4,         32'h4,        64'h1,                  2'd1,
                     5'd0,  1'b0, 32'h0,         1'b0, 32'h0,         32'h0,        64'h0,                  2'd0};

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        // Latency: new ex_wdata must not appear before the edge, then must appear right after it.
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.stall    = 6'b000000;
        bus.ex_waddr = 5'd10;
        bus.ex_we    = 1'b1;
        bus.ex_wdata = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        checkField("latency first", 64'(bus.mem_wdata), 64'h1357_9BDF);
        bus.ex_wdata = 32'h2468_ACE0;
        #2;
        checkField("latency before edge", 64'(bus.mem_wdata), 64'h1357_9BDF);
        @(posedge clk);
        #1;
        checkField("latency after edge", 64'(bus.mem_wdata), 64'h2468_ACE0);

        // Bubble for several cycles while MEM runs: no write may leak through, and the scratch loops.
        for (int k = 0; k < 3; k++) begin
            bus.stall       = 6'b001111;
            bus.ex_we       = 1'b1;
            bus.ex_wdata    = 32'hF000_0000 + 32'(k);
            bus.hilo_temp_i = 64'h100 + 64'(k);
            bus.cnt_i       = 2'(k + 1);
            @(posedge clk);
            #1;
            checkField($sformatf("bubble%0d mem_we", k),    64'(bus.mem_we),    64'd0);
            checkField($sformatf("bubble%0d mem_wdata", k), 64'(bus.mem_wdata), 64'd0);
            checkField($sformatf("bubble%0d cnt_o", k),     64'(bus.cnt_o),     HILO_EN ? 64'(k + 1) : 64'd0);
            checkField($sformatf("bubble%0d hilo_temp_o", k), bus.hilo_temp_o,  HILO_EN ? (64'h100 + 64'(k)) : 64'd0);
        end

        // Release from the bubble: the next advance captures ex_* and clears the scratch.
        bus.stall    = 6'b000000;
        bus.ex_waddr = 5'd12;
        bus.ex_wdata = 32'hC0DE_0001;
        @(posedge clk);
        #1;
        checkField("release mem_waddr", 64'(bus.mem_waddr), 64'd12);
        checkField("release mem_wdata", 64'(bus.mem_wdata), 64'hC0DE_0001);
        checkField("release cnt_o",     64'(bus.cnt_o),     64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core. It latches the execute result (write address, write enable, write data and HI/LO update) on each clock edge. It inserts bubbles and holds values under the central stall vector, and clears on pipeline flush. It also carries the two-cycle multiply-accumulate scratch state (`hilo_temp`, `cnt`) across execute-stage stall cycles, so a `madd`/`msub` can span two clocks.

## Interface
Parameters:
- `DATA_W`, 32, general-purpose register data width (matches `` `RegBus ``)
- `ADDR_W`, 5, register-file address width (matches `` `RegAddrBus ``)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high (`` `RstEnable `` = 1'b1)
- `ex_waddr`  in  ADDR_W  destination register from execute
- `ex_we`  in  1  register write enable from execute
- `ex_wdata`  in  DATA_W  result from execute
- `ex_whilo`  in  1  HI/LO write enable from execute
- `ex_hi`, `ex_lo`  in  DATA_W each  HI/LO values from execute
- `hilo_temp_i`  in  64  multiply-accumulate partial product from execute
- `cnt_i`  in  2  multiply-accumulate cycle counter from execute
- `stall`  in  6  stall vector from control; bit 3 = execute stalled, bit 4 = memory stalled
- `flush`  in  1  pipeline flush (exception)
- `mem_waddr`, `mem_we`, `mem_wdata`, `mem_whilo`, `mem_hi`, `mem_lo`  out  registered counterparts of the `ex_*` inputs
- `hilo_temp_o`  out  64  partial product returned to execute
- `cnt_o`  out  2  cycle counter returned to execute

## Operation
- Every output is a flop.
- At each rising edge, apply the first matching case, in priority order:
  1. `rst` = 1: all outputs ← 0.
  2. `flush` = 1: all outputs ← 0. This covers the multiply-accumulate scratch, so a flush aborts an in-flight `madd`.
  3. `stall[3]` = 1 and `stall[4]` = 0 (bubble):
     - `mem_*` ← 0, so `mem_we` = 0 and `mem_whilo` = 0.
     - `hilo_temp_o` ← `hilo_temp_i`.
     - `cnt_o` ← `cnt_i`.
  4. `stall[3]` = 0 (advance):
     - `mem_*` ← `ex_*`.
     - `hilo_temp_o` ← 0.
     - `cnt_o` ← 0.
  5. `stall[3]` = 1 and `stall[4]` = 1 (hold):
     - `mem_*` keep their values.
     - `hilo_temp_o` ← `hilo_temp_i`.
     - `cnt_o` ← `cnt_i`.
- `stall[4]` = 1 with `stall[3]` = 0 is illegal; control never drives it. If it occurs, the block advances (case 4).
- No arithmetic inside the block. Widths pass through unchanged, and `cnt` is not incremented here.
- `ex_waddr` = 0 with `ex_we` = 1 is latched as-is; suppression of writes to `$zero` is done in the register file.

## Timing
- Latency: exactly 1 cycle from the `ex_*` inputs to the `mem_*` outputs when advancing.
- Scratch loop: `hilo_temp_i`/`cnt_i` captured at edge N appear on `hilo_temp_o`/`cnt_o` after edge N and are combinationally visible to execute in cycle N+1.
- Reset and flush take effect on the edge at which they are sampled high. De-assertion resumes normal operation on the next edge.
- Reset or flush asserted mid-multiply-accumulate (`cnt_o` = 1): `cnt_o` becomes 0 after the edge, and execute restarts the instruction.
- Bubble while MEM runs: `mem_we` is 0 for every cycle in which `stall[3]` = 1 and `stall[4]` = 0.

## Configuration
- Macro `EX_MEM_HILO_EN`.
- Defined:
  - `ex_whilo`, `ex_hi` and `ex_lo` are registered per the rules above.
  - `hilo_temp` and `cnt` pass through per the rules above.
- Undefined:
  - The HI/LO and multiply-accumulate flops are not synthesized.
  - `mem_whilo`, `mem_hi`, `mem_lo`, `hilo_temp_o` and `cnt_o` are tied to constant 0.
  - The corresponding inputs are ignored.
  - Ports stay present so instantiation is unchanged.

## Test plan
- Reset:
  - Stimulus: drive all inputs nonzero and hold `rst` = 1 for 2 edges.
  - Required: every output = 0. After `rst` falls with `stall` = 0, `mem_wdata` follows `ex_wdata` one cycle later.
- Advance:
  - Stimulus: `ex_waddr` = 5'd3, `ex_we` = 1, `ex_wdata` = 32'h0000_F0F0, `stall` = 0.
  - Required: after the edge, `mem_waddr` = 3, `mem_we` = 1, `mem_wdata` = 32'h0000_F0F0, `cnt_o` = 0.
- Bubble:
  - Stimulus: `stall` = 6'b001111 with `ex_we` = 1 and `ex_wdata` = 32'h1234_5678.
  - Required: `mem_we` = 0 and `mem_wdata` = 0.
  - Stimulus: additionally `hilo_temp_i` = 64'hA, `cnt_i` = 1.
  - Required: `hilo_temp_o` = 64'hA and `cnt_o` = 1 after the edge.
- Hold:
  - Stimulus: latch `mem_wdata` = 32'hDEAD_BEEF, then apply `stall` = 6'b011111 for 3 cycles while `ex_wdata` changes.
  - Required: `mem_wdata` stays 32'hDEAD_BEEF.
- Flush priority:
  - Stimulus: `flush` = 1 together with `stall` = 6'b011111, `cnt_i` = 1 and `hilo_temp_i` = 64'h5.
  - Required: all outputs = 0 after the edge.
- `EX_MEM_HILO_EN` undefined:
  - Stimulus: `ex_whilo` = 1, `ex_hi` = 32'hFFFF_FFFF, `stall` = 0.
  - Required: `mem_whilo` = 0 and `mem_hi` = 0.
